// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants and FSM state type for the round-robin arbiter
package rr_arb_pkg;

    localparam int N_DEFAULT     = 16;
    localparam int IDX_W_DEFAULT = 4;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter16_if.sv
// rtl/rr_arbiter16_if.sv - request/grant handshake bundle; stall_cnt present under RR_ARB_STALL_CNT_EN
interface rr_arbiter16_if #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
);
    logic             enable;
    logic [N-1:0]     req;
    logic             grant_valid;
    logic             grant_ready;
    logic [N-1:0]     grant_onehot;
    logic [IDX_W-1:0] grant_idx;
`ifdef RR_ARB_STALL_CNT_EN
    logic [15:0]      stall_cnt;

    modport master (
        input  enable, req, grant_ready,
        output grant_valid, grant_onehot, grant_idx, stall_cnt
    );
    modport slave (
        output enable, req, grant_ready,
        input  grant_valid, grant_onehot, grant_idx, stall_cnt
    );
`else
    modport master (
        input  enable, req, grant_ready,
        output grant_valid, grant_onehot, grant_idx
    );
    modport slave (
        output enable, req, grant_ready,
        input  grant_valid, grant_onehot, grant_idx
    );
`endif
endinterface

// File: rtl/rr_arbiter16_pick16.sv
// rtl/rr_arbiter16_pick16.sv - combinational round-robin pick: masked priority encode with unmasked fallback
module rr_pick16 #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);
    logic [N-1:0] w_masked;
    logic [N-1:0] w_src;

    always_comb begin
        w_masked = '0;
        for (int i = 0; i < N; i++) begin
            w_masked[i] = i_req[i] && (IDX_W'(i) >= i_ptr);
        end
        // No request at or above ptr means the search has wrapped to bit 0.
        w_src = (|w_masked) ? w_masked : i_req;
        o_any = |i_req;
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_src[i]) begin
                o_idx = IDX_W'(i);
            end
        end
        o_onehot = o_any ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/rr_arbiter16.sv
// rtl/rr_arbiter16.sv - registered round-robin arbiter with one-hot and index grant; RR_ARB_STALL_CNT_EN adds stall_cnt
module rr_arbiter16
    import rr_arb_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int IDX_W = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter16_if.master bus
);
    arb_state_t       r_state;
    logic             r_valid;
    logic [N-1:0]     r_onehot;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_ptr;

    logic [N-1:0]     w_win_onehot;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_any;
    logic             w_load;

    rr_pick16 #(.N(N), .IDX_W(IDX_W)) u_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_any    (w_any)
    );

    assign w_load = bus.enable && w_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_onehot <= '0;
            r_idx    <= '0;
            r_ptr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state  <= ST_HOLD;
                        r_valid  <= 1'b1;
                        r_onehot <= w_win_onehot;
                        r_idx    <= w_win_idx;
                        r_ptr    <= w_win_idx + 1'b1;
                    end
                end
                ST_HOLD: begin
                    // Held grant stays frozen until the consumer takes it.
                    if (bus.grant_ready) begin
                        if (w_load) begin
                            r_onehot <= w_win_onehot;
                            r_idx    <= w_win_idx;
                            r_ptr    <= w_win_idx + 1'b1;
                        end else begin
                            r_state  <= ST_IDLE;
                            r_valid  <= 1'b0;
                            r_onehot <= '0;
                            r_idx    <= '0;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_valid  <= 1'b0;
                    r_onehot <= '0;
                    r_idx    <= '0;
                end
            endcase
        end
    end

    assign bus.grant_valid  = r_valid;
    assign bus.grant_onehot = r_onehot;
    assign bus.grant_idx    = r_idx;

`ifdef RR_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (r_valid && !bus.grant_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_rr_arbiter16.sv
// tb/tb_rr_arbiter16.sv - directed bench with per-cycle reference model for rr_arbiter16
module tb_rr_arbiter16;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rr_arbiter16_if #(.N(16)) bus ();

    rr_arbiter16 #(.N(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: scan upward from ptr with wrap, first requester wins.
    bit m_valid;
    int m_idx;
    int m_ptr;
    int m_stall;

    function automatic int pick(logic [15:0] r, int p);
        for (int k = 0; k < 16; k++) begin
            if (r[(p + k) % 16]) return (p + k) % 16;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int w;
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_ptr   <= 0;
            m_stall <= 0;
        end else begin
            if (m_valid && !bus.grant_ready && m_stall < 65535) m_stall <= m_stall + 1;
            if (!m_valid || bus.grant_ready) begin
                w = pick(bus.req, m_ptr);
                if (bus.enable && w >= 0) begin
                    m_valid <= 1'b1;
                    m_idx   <= w;
                    m_ptr   <= (w + 1) % 16;
                end else begin
                    m_valid <= 1'b0;
                    m_idx   <= 0;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [15:0] e_oh;
        logic [3:0]  e_idx;
        e_oh  = m_valid ? (16'd1 << m_idx) : 16'd0;
        e_idx = m_valid ? 4'(m_idx) : 4'd0;
        total++;
        if (bus.grant_valid !== m_valid || bus.grant_onehot !== e_oh || bus.grant_idx !== e_idx) begin
            bad++;
            $display("FAIL model_cmp t=%0t got v=%0b oh=%h idx=%0d exp v=%0b oh=%h idx=%0d",
                     $time, bus.grant_valid, bus.grant_onehot, bus.grant_idx, m_valid, e_oh, e_idx);
        end
`ifdef RR_ARB_STALL_CNT_EN
        total++;
        if (bus.stall_cnt !== 16'(m_stall)) begin
            bad++;
            $display("FAIL model_stall t=%0t got %0d exp %0d", $time, bus.stall_cnt, m_stall);
        end
`endif
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got %h exp %h", name, act, exp);
        end
    endtask

    task automatic chk_grant(string name, logic v, logic [15:0] oh, logic [3:0] idx);
        chk({name, "_valid"}, 32'(bus.grant_valid), 32'(v));
        chk({name, "_onehot"}, 32'(bus.grant_onehot), 32'(oh));
        chk({name, "_idx"}, 32'(bus.grant_idx), 32'(idx));
    endtask

    task automatic step(logic en, logic [15:0] rq, logic rdy);
        bus.enable      = en;
        bus.req         = rq;
        bus.grant_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.enable      = 1'b0;
        bus.req         = 16'h0000;
        bus.grant_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        bus.enable      = 1'b0;
        bus.req         = 16'h0000;
        bus.grant_ready = 1'b0;
        #2;
        do_reset();
        chk_grant("reset", 1'b0, 16'h0000, 4'd0);
`ifdef RR_ARB_STALL_CNT_EN
        chk("reset_stall", 32'(bus.stall_cnt), 32'd0);
`endif

        for (int i = 0; i < 5; i++) begin
            step(1'b1, 16'h0000, 1'b1);
            chk_grant("noreq", 1'b0, 16'h0000, 4'd0);
        end

        for (int i = 0; i < 17; i++) begin
            step(1'b1, 16'hFFFF, 1'b1);
            chk_grant($sformatf("rot%0d", i), 1'b1, 16'd1 << (i % 16), 4'(i % 16));
        end
        step(1'b1, 16'h0000, 1'b1);
        chk_grant("rot_drain", 1'b0, 16'h0000, 4'd0);

        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h8001, 1'b1);
            chk_grant($sformatf("alt%0d", i), 1'b1, (i % 2) ? 16'h8000 : 16'h0001, (i % 2) ? 4'd15 : 4'd0);
        end
        step(1'b1, 16'h0000, 1'b1);
        chk_grant("alt_drain", 1'b0, 16'h0000, 4'd0);

        step(1'b1, 16'h0010, 1'b0);
        chk_grant("stall1", 1'b1, 16'h0010, 4'd4);
        for (int i = 2; i <= 5; i++) begin
            step(1'b1, 16'h0000, 1'b0);
            chk_grant($sformatf("stall%0d", i), 1'b1, 16'h0010, 4'd4);
        end
`ifdef RR_ARB_STALL_CNT_EN
        chk("stall_cnt", 32'(bus.stall_cnt), 32'd4);
`endif
        step(1'b1, 16'h0000, 1'b1);
        chk_grant("stall_accept", 1'b0, 16'h0000, 4'd0);

        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h00FF, 1'b1);
            chk_grant("en_off", 1'b0, 16'h0000, 4'd0);
        end
        step(1'b1, 16'h00FF, 1'b1);
        chk_grant("en_on", 1'b1, 16'h0001, 4'd0);
        step(1'b1, 16'h0000, 1'b1);

        do_reset();
        step(1'b1, 16'h0200, 1'b0);
        chk_grant("hold9", 1'b1, 16'h0200, 4'd9);
        step(1'b1, 16'h0000, 1'b0);
        chk_grant("hold9b", 1'b1, 16'h0200, 4'd9);
        #1 rst_n = 1'b0;
        #1;
        chk_grant("async_rst", 1'b0, 16'h0000, 4'd0);
        bus.enable      = 1'b1;
        bus.req         = 16'hFFFF;
        bus.grant_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_grant("post_rst", 1'b1, 16'h0001, 4'd0);
        step(1'b1, 16'hFFFF, 1'b1);
        chk_grant("post_rst2", 1'b1, 16'h0002, 4'd1);

        step(1'b1, 16'h0000, 1'b1);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
